// File: rtl/one_addr_pkg.sv
// Shared constants for the one_addr feeder/detector pair: FSM encoding,
// width helper and counter widths.
package one_addr_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE       = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE      = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT_START = 2'd2;
  localparam logic [STATE_W-1:0] S_WAIT_DONE  = 2'd3;

  localparam int ZERO_CNT_W = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_N = 5;
  localparam int ADDR_W    = clog2w(DEFAULT_N);

endpackage

// File: rtl/one_addr_fifo.sv
// Synchronous show-ahead FIFO; rdata always presents the head entry.
module one_addr_fifo
  import one_addr_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/one_addr_feeder.sv
// Issue stage for one_addr_detect: buffers producer words and hands them
// to the detector one at a time, waiting for each to finish.
module one_addr_feeder
  import one_addr_pkg::*;
#(
  parameter int N       = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [N-1:0]          data,
  output logic                  vld_i,
  input  logic                  vld_o,
  output logic                  busy,
  output logic                  err,
  output logic [ZERO_CNT_W-1:0] zero_cnt
);

  localparam int TIMER_W = clog2w(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [N-1:0]          data_q, data_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  err_q, err_d;
  logic [ZERO_CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  logic                  accept;
  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [N-1:0]          fifo_rdata;

  one_addr_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready depends only on registered occupancy.
  assign in_rdy   = !fifo_full;
  assign data     = data_q;
  assign vld_i    = (state_q == S_ISSUE);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign zero_cnt = zero_cnt_q;

  always_comb begin
    accept     = in_vld && in_rdy;
    fifo_push  = accept && (in_data != '0);
    zero_cnt_d = zero_cnt_q;
    if (accept && (in_data == '0) && (zero_cnt_q != '1))
      zero_cnt_d = zero_cnt_q + 1'b1;

    state_d  = state_q;
    data_d   = data_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (vld_o) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!vld_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule
